// File: rtl/mc_control.sv
// Multi-cycle Moore control FSM for the Lab3 MIPS-subset CPU, with a retired-instruction counter.
// Optional memory handshake: define MC_CTRL_MEMWAIT_EN to stall IF/MEMRD/MEMWR until mem_ready.
module mc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             regdst,
    output logic             memtoreg,
    output logic             write_reg,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic             ext_zero,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    // state  | meaning
    // IDLE   | after reset, nothing driven
    // IF     | fetch, PC += 4
    // ID     | decode, branch target precomputed
    // MEMADR | lw/sw address
    // MEMRD  | lw data read
    // MEMWB  | lw register write-back
    // MEMWR  | sw data write
    // EXR    | R-type ALU operation
    // WBR    | R-type write-back
    // BEQ    | branch compare
    // JMP    | jump
    // EXI    | addi/ori ALU operation
    // WBI    | immediate write-back
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXR    = 4'd7,
        S_WBR    = 4'd8,
        S_BEQ    = 4'd9,
        S_JMP    = 4'd10,
        S_EXI    = 4'd11,
        S_WBI    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_ok;

    // The ALU decodes funct itself; the controller only passes aluop=10.
    logic funct_unused;
    assign funct_unused = ^funct;

`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_ok = mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        regdst        = 1'b0;
        memtoreg      = 1'b0;
        write_reg     = 1'b0;
        alusrc_a      = 1'b0;
        alusrc_b      = 2'b00;
        ext_zero      = 1'b0;
        aluop         = 2'b00;
        pcsource      = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                mem_read = 1'b1;
                alusrc_b = 2'b01;
                if (mem_ok) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                alusrc_b = 2'b11;
                case (opcode)
                    OP_RTYPE:        state_d = S_EXR;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:          state_d = S_BEQ;
                    OP_J:            state_d = S_JMP;
                    OP_ADDI, OP_ORI: state_d = S_EXI;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_IF;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
                state_d  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ok) begin
                    instr_done = 1'b1;
                    state_d    = S_IF;
                end
            end
            S_MEMWB: begin
                write_reg  = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_EXR: begin
                alusrc_a = 1'b1;
                aluop    = 2'b10;
                state_d  = S_WBR;
            end
            S_WBR: begin
                write_reg  = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_BEQ: begin
                alusrc_a      = 1'b1;
                aluop         = 2'b01;
                pc_write_cond = 1'b1;
                pcsource      = 2'b01;
                instr_done    = 1'b1;
                state_d       = S_IF;
            end
            S_JMP: begin
                pc_write   = 1'b1;
                pcsource   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            S_EXI: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
                if (opcode == OP_ORI) begin
                    aluop    = 2'b11;
                    ext_zero = 1'b1;
                end
                state_d = S_WBI;
            end
            S_WBI: begin
                write_reg  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_IF;
            end
            // Encodings 13-15 recover like IDLE
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (instr_done) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized instruction-stream bench for mc_control against a per-instruction phase model.
// Builds for either setting of MC_CTRL_MEMWAIT_EN.
module tb_mc_control;
    localparam int CNT_W = 4;
`ifdef MC_CTRL_MEMWAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       regdst;
        logic       memtoreg;
        logic       write_reg;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic       ext_zero;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       done;
        logic       ill;
    } out_t;

    logic clk = 1'b0, rst = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic mem_ready = 1'b0;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic regdst, memtoreg, write_reg, alusrc_a, ext_zero, instr_done, illegal;
    logic [1:0] alusrc_b, aluop, pcsource;
    logic [3:0] state;
    logic [CNT_W-1:0] instr_cnt;

    always #5 clk = ~clk;

    mc_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .regdst(regdst), .memtoreg(memtoreg), .write_reg(write_reg),
        .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .ext_zero(ext_zero),
        .aluop(aluop), .pcsource(pcsource), .state(state),
        .instr_done(instr_done), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    out_t dut_v;
    assign dut_v = '{pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     regdst, memtoreg, write_reg, alusrc_a, alusrc_b, ext_zero,
                     aluop, pcsource, instr_done, illegal};

    int n_vec = 0, n_err = 0;
    int seq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd13};
    endfunction

    // Phases an instruction walks through, by its documented state numbers
    function automatic void build_seq(input logic [5:0] op);
        seq.delete();
        seq.push_back(1);
        seq.push_back(2);
        case (op)
            6'd0:        begin seq.push_back(7); seq.push_back(8); end
            6'd35:       begin seq.push_back(3); seq.push_back(4); seq.push_back(5); end
            6'd43:       begin seq.push_back(3); seq.push_back(6); end
            6'd4:        seq.push_back(9);
            6'd2:        seq.push_back(10);
            6'd8, 6'd13: begin seq.push_back(11); seq.push_back(12); end
            default:     ;
        endcase
    endfunction

    function automatic out_t exp_out(input int ph, input logic [5:0] op, input bit rdy);
        out_t o;
        bit   go;
        o  = '0;
        go = rdy || !WAIT_EN;
        case (ph)
            1:  begin o.mem_read = 1; o.alusrc_b = 2'b01; o.ir_write = go; o.pc_write = go; end
            2:  begin o.alusrc_b = 2'b11; o.done = !legal(op); o.ill = !legal(op); end
            3:  begin o.alusrc_a = 1; o.alusrc_b = 2'b10; end
            4:  begin o.mem_read = 1; o.iord = 1; end
            5:  begin o.write_reg = 1; o.memtoreg = 1; o.done = 1; end
            6:  begin o.mem_write = 1; o.iord = 1; o.done = go; end
            7:  begin o.alusrc_a = 1; o.aluop = 2'b10; end
            8:  begin o.write_reg = 1; o.regdst = 1; o.done = 1; end
            9:  begin o.alusrc_a = 1; o.aluop = 2'b01; o.pc_write_cond = 1; o.pcsource = 2'b01; o.done = 1; end
            10: begin o.pc_write = 1; o.pcsource = 2'b10; o.done = 1; end
            11: begin
                    o.alusrc_a = 1; o.alusrc_b = 2'b10;
                    if (op == 6'd13) begin o.aluop = 2'b11; o.ext_zero = 1; end
                end
            12: begin o.write_reg = 1; o.done = 1; end
            default: ;
        endcase
        return o;
    endfunction

    initial begin
        logic [5:0] directed [7];
        logic [5:0] legal_ops [7];
        int   lw_states [5];
        logic [5:0] cur_op;
        bit   idle, need_pick, rdy, did_rst;
        int   pos, mcnt, ph, ndir;
        out_t e;

        directed  = '{6'd35, 6'd0, 6'd8, 6'd13, 6'd4, 6'd2, 6'd63};
        legal_ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd13};
        lw_states = '{1, 2, 3, 4, 5};
        cur_op = '0; idle = 1; need_pick = 0; did_rst = 0; pos = 0; mcnt = 0; ndir = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cnt", 32'(instr_cnt), 32'd0);
        chk("reset_outputs", 32'(dut_v), 32'd0);
        rst = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            if (!idle && need_pick) begin
                if (ndir < 7) begin
                    cur_op = directed[ndir];
                    ndir++;
                end else if ($urandom_range(0, 9) < 7) begin
                    cur_op = legal_ops[$urandom_range(0, 6)];
                end else begin
                    cur_op = 6'($urandom);
                end
                opcode = cur_op;
                funct  = 6'($urandom);
                build_seq(cur_op);
                need_pick = 0;
            end
            rdy = (c < 30) ? 1'b1 : 1'($urandom_range(0, 1));
            mem_ready = rdy;
            ph = idle ? 0 : seq[pos];
            #1;
            e = exp_out(ph, cur_op, rdy);
            chk("outputs", 32'(dut_v), 32'(e));
            chk("state", 32'(state), 32'(ph));
            chk("instr_cnt", 32'(instr_cnt), 32'(mcnt % (1 << CNT_W)));
            if (c >= 1 && c <= 5) chk("lw_state_literal", 32'(state), 32'(lw_states[c-1]));
            if (c == 26) begin
                chk("directed_cnt_literal", 32'(instr_cnt), 32'd7);
                chk("directed_if_literal", 32'(state), 32'd1);
            end

            if (ph == 8 && c > 100 && !did_rst) begin
                did_rst = 1;
                #1 rst = 1'b0;
                #1;
                chk("midrst_state", 32'(state), 32'd0);
                chk("midrst_write_reg", 32'(write_reg), 32'd0);
                chk("midrst_cnt", 32'(instr_cnt), 32'd0);
                repeat (2) @(negedge clk);
                rst = 1'b1;
                idle = 1; pos = 0; mcnt = 0;
                continue;
            end

            if (idle) begin
                idle = 0; pos = 0; need_pick = 1;
            end else begin
                if (e.done) mcnt++;
                if (!(ph == 1 || ph == 4 || ph == 6) || rdy || !WAIT_EN) pos++;
                if (pos >= seq.size()) begin
                    pos = 0; need_pick = 1;
                end
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
